// File: rtl/memrw_fb.sv
// memrw_fb -- SDRAM framebuffer writer/reader.
//
// Write side: parses a little-endian command byte stream into single-word
// SDRAM writes. Commands are found by sliding a 4-byte header window over the
// stream, so garbage bytes are skipped without losing the alignment of a later
// valid header.
//   WRITE header: 55 AA above a 16-bit word count len (bytes: len_lo len_hi 55 AA),
//                 then a 4-byte address, then len words of NB bytes each.
//                 Address bit 31 set means the payload is consumed and dropped.
//   FLIP header:  5A AA (bytes: xx xx 5A AA); requests a frame buffer swap that
//                 takes effect at the next frame wrap.
// Read side: keeps the video line FIFO fed with burst reads. Reads start when the
// FIFO level falls to THR_LOW and stop once it reaches THR_HIGH. Read addresses
// walk HREADS bursts per line and LINES lines per frame.
//
// Handshakes:
//   in_valid/in_ready - a byte transfers on every mem_clk edge where both are high;
//                       in_ready does not depend on in_valid.
//   mem_rd_req / mem_wr_req - level requests, held until mem_ack is sampled high and
//                       dropped on that same edge. At most one of the two is high at
//                       any time, so mem_ack always belongs to the request that is high.
//   mem_wr_data_next  - after a write is acked, mem_wr_data stays stable until the
//                       controller pulses mem_wr_data_next.
//
// Ports:
//   mem_clk, reset            clock; synchronous active-high reset
//   in_valid, in_data, in_ready   command byte input
//   mem_ack                   controller accepted the pending rd or wr request
//   mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_data_next   single-word write
//   mem_rd_req, mem_rd_addr   burst read request and its start address
//   fifo_level                video FIFO fill level
//   frame_sel                 frame buffer being scanned out
//   flip_pending              FLIP received but not yet applied
//   dbg_state                 current command-parser state (encoding of state_t)
//
// Assumes DW >= 16 and AW < 32 (address bit 31 is the discard flag).
module memrw_fb #(
    parameter int               AW       = 25,
    parameter int               DW       = 32,
    parameter int               LVL_W    = 2,
    parameter logic [LVL_W-1:0] THR_HIGH = LVL_W'(3),
    parameter logic [LVL_W-1:0] THR_LOW  = LVL_W'(1),
    parameter int               HREADS   = 80,
    parameter int               LINES    = 720,
    parameter int               BURST    = 8,
    parameter int               STRIDE   = 1024,
    parameter int               FB1_BASE = 2**20
) (
    input  logic             mem_clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             mem_ack,
    output logic             mem_wr_req,
    output logic [AW-1:0]    mem_wr_addr,
    output logic [DW-1:0]    mem_wr_data,
    input  logic             mem_wr_data_next,
    output logic             mem_rd_req,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [LVL_W-1:0] fifo_level,
    output logic             frame_sel,
    output logic             flip_pending,
    output logic [2:0]       dbg_state
);

    localparam int NB   = DW / 8;
    localparam int HR_W = (HREADS > 1) ? $clog2(HREADS) : 1;
    localparam int LN_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [7:0]      PAY_LAST = 8'(NB - 1);
    localparam logic [HR_W-1:0] HR_LAST  = HR_W'(HREADS - 1);
    localparam logic [LN_W-1:0] LN_LAST  = LN_W'(LINES - 1);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_ADDR  = 3'd1,
        S_PAY   = 3'd2,
        S_WIN   = 3'd3,
        S_WR    = 3'd4,
        S_WDATA = 3'd5
    } state_t;

    state_t state, state_n;

    logic [31:0]     hdr;
    logic [15:0]     len;
    logic [31:0]     addr;
    logic [DW-1:0]   word;
    logic [7:0]      bcnt;
    logic [15:0]     wcnt;

    logic            need_feed;
    logic [HR_W-1:0] hread, hread_n;
    logic [LN_W-1:0] line, line_n;
    logic            frame_n, flip_n, wrap;

    logic            take;
    logic [31:0]     hdr_shift;
    logic [31:0]     addr_shift;
    logic [DW-1:0]   word_shift;
    logic            is_write, is_flip;
    logic            last_addr_byte, last_pay_byte, wlast;
    logic            rd_ack, rd_set;
    logic [AW-1:0]   rd_addr_n;

    assign in_ready  = ((state == S_HDR) || (state == S_ADDR) || (state == S_PAY)) && !reset;
    assign take      = in_valid && in_ready;

    // Newest byte always enters at the top, so after N bytes the word is little-endian.
    assign hdr_shift  = {in_data, hdr[31:8]};
    assign addr_shift = {in_data, addr[31:8]};
    assign word_shift = {in_data, word[DW-1:8]};

    // Opcode is the new byte over the previous newest byte; checked on every header byte.
    assign is_write = take && (state == S_HDR) && ({in_data, hdr[31:24]} == 16'hAA55);
    assign is_flip  = take && (state == S_HDR) && ({in_data, hdr[31:24]} == 16'hAA5A);

    assign last_addr_byte = (bcnt == 8'd3);
    assign last_pay_byte  = (bcnt == PAY_LAST);
    assign wlast          = (wcnt == len - 16'd1);

    assign mem_wr_addr = addr[AW-1:0];
    assign mem_wr_data = word;
    assign dbg_state   = state;

    // ---------------- command parser FSM ----------------
    always_ff @(posedge mem_clk) begin
        if (reset) state <= S_HDR;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_HDR:   if (is_write) state_n = S_ADDR;
            S_ADDR:  if (take && last_addr_byte) state_n = (len == 16'd0) ? S_HDR : S_PAY;
            S_PAY:   if (take && last_pay_byte) begin
                         if (!addr[31])  state_n = S_WIN;
                         else if (wlast) state_n = S_HDR;
                         else            state_n = S_PAY;
                     end
            // A read already outstanding is allowed to finish before the write goes out.
            S_WIN:   if (!mem_rd_req) state_n = S_WR;
            S_WR:    if (mem_ack) state_n = S_WDATA;
            S_WDATA: if (mem_wr_data_next) state_n = wlast ? S_HDR : S_PAY;
            default: state_n = S_HDR;
        endcase
    end

    // ---------------- write datapath ----------------
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            hdr        <= '0;
            len        <= '0;
            addr       <= '0;
            word       <= '0;
            bcnt       <= '0;
            wcnt       <= '0;
            mem_wr_req <= 1'b0;
        end else begin
            case (state)
                S_HDR: if (take) begin
                    hdr <= is_flip ? 32'h0 : hdr_shift;
                    if (is_write) begin
                        len  <= hdr_shift[15:0];
                        bcnt <= '0;
                    end
                end
                S_ADDR: if (take) begin
                    addr <= addr_shift;
                    bcnt <= last_addr_byte ? 8'd0 : bcnt + 8'd1;
                    wcnt <= '0;
                end
                S_PAY: if (take) begin
                    word <= word_shift;
                    if (last_pay_byte) begin
                        bcnt <= '0;
                        if (addr[31]) wcnt <= wcnt + 16'd1;
                    end else begin
                        bcnt <= bcnt + 8'd1;
                    end
                end
                S_WIN: if (!mem_rd_req) mem_wr_req <= 1'b1;
                S_WR:  if (mem_ack) mem_wr_req <= 1'b0;
                S_WDATA: if (mem_wr_data_next) begin
                    // Only the memory-visible address bits wrap; the flag bits are kept.
                    addr <= {addr[31:AW], addr[AW-1:0] + AW'(1)};
                    wcnt <= wcnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- read feeder ----------------
    assign rd_ack = mem_rd_req && mem_ack;
    // No new read once a write has claimed the bus (WIN/WR/WDATA).
    assign rd_set = !mem_rd_req && need_feed &&
                    (state != S_WIN) && (state != S_WR) && (state != S_WDATA);

    always_comb begin
        hread_n = hread;
        line_n  = line;
        wrap    = 1'b0;
        if (rd_ack) begin
            if (hread == HR_LAST) begin
                hread_n = '0;
                if (line == LN_LAST) begin
                    line_n = '0;
                    wrap   = 1'b1;
                end else begin
                    line_n = line + 1'b1;
                end
            end else begin
                hread_n = hread + 1'b1;
            end
        end
        frame_n = (wrap && flip_pending) ? ~frame_sel : frame_sel;
        // A FLIP landing on the wrap edge is kept for the following wrap.
        flip_n  = is_flip || (flip_pending && !wrap);
        // Address is computed from next-state counters so it is valid with the request.
        rd_addr_n = (frame_n ? AW'(FB1_BASE) : AW'(0))
                  + AW'(line_n) * AW'(STRIDE)
                  + AW'(hread_n) * AW'(BURST);
    end

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            need_feed    <= 1'b0;
            mem_rd_req   <= 1'b0;
            hread        <= '0;
            line         <= '0;
            frame_sel    <= 1'b0;
            flip_pending <= 1'b0;
            mem_rd_addr  <= '0;
        end else begin
            if (fifo_level <= THR_LOW)       need_feed <= 1'b1;
            else if (fifo_level >= THR_HIGH) need_feed <= 1'b0;

            if (rd_ack)      mem_rd_req <= 1'b0;
            else if (rd_set) mem_rd_req <= 1'b1;

            hread        <= hread_n;
            line         <= line_n;
            frame_sel    <= frame_n;
            flip_pending <= flip_n;
            mem_rd_addr  <= rd_addr_n;
        end
    end

endmodule
